change_dispenser: RTL and testbench
===================================

# change_dispenser

Coin-return FSM for the vending datapath: it emits coins where the coin-accept FSM takes them in. On a start pulse it latches an amount owed, in nickel units. It then dispenses the largest coin that fits, one coin per handshake, using the same 2-bit coin code the accept side decodes (01 = nickel, 10 = dime). It reports completion with a one-cycle done pulse and sits between the vending controller and the coin-ejection mechanism.

## Interface
- AMT_W, default 4: width of amount and of the remaining-amount register, in nickel units (4 gives 0..75 cents). Must be ≥ 3.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- start  in  1  request to dispense `amount`; sampled only in IDLE.
- amount  in  AMT_W  change owed, in nickels; sampled with start.
- coin_ready  in  1  ejection mechanism accepts the presented coin this cycle.
- coin  out  2  coin code: 00 none, 01 nickel, 10 dime, 11 quarter (only with macro).
- coin_valid  out  1  `coin` is presented.
- busy  out  1  transaction in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse: transaction complete.
- coin_count  out  AMT_W  coins dispensed in the current or last transaction.

## Operation
- States: IDLE, DISPENSE, DONE. Moore outputs, decoded from registered state and `rem` only.
- IDLE + start:
  - latch rem ← amount; clear coin_count.
  - go to DISPENSE if amount ≠ 0, else DONE.
- DISPENSE:
  - coin_valid = 1.
  - coin = quarter if macro and rem ≥ 5; else dime if rem ≥ 2; else nickel.
- Transfer occurs when coin_valid && coin_ready. On transfer:
  - rem ← rem − value (nickel 1, dime 2, quarter 5); coin_count ← coin_count + 1.
  - If the new rem = 0, go to DONE; else stay in DISPENSE.
- The selected coin never exceeds rem, so the subtraction cannot underflow. coin_count is AMT_W bits and cannot overflow, because coins ≤ amount.
- DONE: done = 1 for exactly one cycle, then IDLE. coin_count holds until the next accepted start.
- start while busy: ignored; the current transaction is unaffected and no queueing occurs.
- Handshake: once coin_valid rises, coin and coin_valid stay stable until transfer. rem changes only on transfer.
- Reset asserted mid-transaction: the transaction is abandoned immediately, with no done pulse and no partial credit. The next start after reset deasserts is served normally.
- Reset values: coin = 00, coin_valid = 0, busy = 0, done = 0, coin_count = 0, rem = 0, state = IDLE.

## Timing
- start sampled at edge 0 → busy and coin_valid high after edge 0 (cycle 1).
- With coin_ready held high, one coin transfers per cycle.
- Total latency from start to done = N + 1 cycles, where N is the coin count:
  - done is high in cycle N + 1; IDLE again in cycle N + 2.
  - amount = 0: done in cycle 1 with no coin_valid.
- Each coin_ready low cycle adds exactly one cycle of latency.
- Back-to-back operation: a start in the cycle IDLE is re-entered is accepted. A start during DONE is ignored.

## Configuration
- CHANGE_QUARTER_EN defined: quarter (11, value 5) is enabled and selected first when rem ≥ 5.
- CHANGE_QUARTER_EN undefined: only dimes and nickels are used; code 11 is never driven. N = floor(amount/2) + (amount mod 2).

## Structure
- Shared package `coin_pkg` holds:
  - coin code constants: COIN_NONE, COIN_NICKEL, COIN_DIME, COIN_QUARTER;
  - coin value constants, in nickels;
  - the state typedef {IDLE, DISPENSE, DONE}.
- The accept-side FSM uses the same package, so the coin encodings stay identical on both ends.
- Natural sub-module: `coin_select`, combinational. It maps rem to the coin code and its value, so the quarter macro is confined to one place.

## Test plan
- amount = 3, coin_ready = 1 → dime in cycle 1, nickel in cycle 2, done in cycle 3, coin_count = 2.
- amount = 0 → coin_valid never asserts; done in cycle 1; coin_count = 0.
- amount = 4, coin_ready low for cycles 1–3 → coin = 10 held stable; dimes transfer in cycles 4 and 5, done in cycle 6, coin_count = 2.
- amount = 5 accepted, then start with amount = 7 in cycle 2 → second start ignored; coin sequence is dime, dime, nickel only.
- amount = 6, reset pulse after the first dime → all outputs at reset values with no done pulse; a following start with amount = 1 yields one nickel and done.
- amount = 7:
  - with CHANGE_QUARTER_EN → quarter, dime; done in cycle 3.
  - without the macro → dime, dime, dime, nickel; done in cycle 5.

Source files
------------

// File: rtl/coin_pkg.sv
// Coin codes, coin values (in nickels) and dispenser state encoding,
// shared by the coin-accept and coin-return FSMs.
package coin_pkg;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    localparam int VAL_NICKEL  = 1;
    localparam int VAL_DIME    = 2;
    localparam int VAL_QUARTER = 5;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t DISPENSE = 2'd1;
    localparam state_t DONE     = 2'd2;

endpackage

// File: rtl/change_dispenser_if.sv
// Request / coin-ejection handshake bundle of the change dispenser.
// master = controller and ejection side, slave = dispenser.
interface change_dispenser_if #(
    parameter int AMT_W = 4
);
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             coin_ready;
    logic [1:0]       coin;
    logic             coin_valid;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] coin_count;

    modport master (
        output start, amount, coin_ready,
        input  coin, coin_valid, busy, done, coin_count
    );

    modport slave (
        input  start, amount, coin_ready,
        output coin, coin_valid, busy, done, coin_count
    );
endinterface

// File: rtl/change_dispenser_coin_select.sv
// Largest coin not exceeding the remaining amount, with its value.
// Quarters are only offered when CHANGE_QUARTER_EN is defined.
module coin_select
    import coin_pkg::*;
#(
    parameter int AMT_W = 4
) (
    input  logic [AMT_W-1:0] rem_i,
    output logic [1:0]       coin_o,
    output logic [AMT_W-1:0] val_o
);

    // Later matches override earlier ones: biggest fitting coin wins
    always_comb begin
        coin_o = COIN_NICKEL;
        val_o  = AMT_W'(VAL_NICKEL);
        if (rem_i >= AMT_W'(VAL_DIME)) begin
            coin_o = COIN_DIME;
            val_o  = AMT_W'(VAL_DIME);
        end
`ifdef CHANGE_QUARTER_EN
        if (rem_i >= AMT_W'(VAL_QUARTER)) begin
            coin_o = COIN_QUARTER;
            val_o  = AMT_W'(VAL_QUARTER);
        end
`endif
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin-return FSM: pays out an owed amount one coin per handshake.
// Optional quarter support via CHANGE_QUARTER_EN (see coin_select).
module change_dispenser
    import coin_pkg::*;
#(
    parameter int AMT_W = 4
) (
    input logic               clock,
    input logic               reset,
    change_dispenser_if.slave bus
);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_coin;
    logic [AMT_W-1:0] sel_val;

    coin_select #(.AMT_W(AMT_W)) u_sel (
        .rem_i  (rem_q),
        .coin_o (sel_coin),
        .val_o  (sel_val)
    );

    // Next state: latch on start, debit on transfer, one DONE cycle
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d   = bus.amount;
                    cnt_d   = '0;
                    state_d = (bus.amount != '0) ? DISPENSE : DONE;
                end
            end
            DISPENSE: begin
                if (bus.coin_ready) begin
                    rem_d = rem_q - sel_val;
                    cnt_d = cnt_q + AMT_W'(1);
                    if (rem_q == sel_val)
                        state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs: the coin is only driven while dispensing
    assign bus.coin_valid = (state_q == DISPENSE);
    assign bus.coin       = bus.coin_valid ? sel_coin : COIN_NONE;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.coin_count = cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: greedy-change reference model,
// coin/done monitor, latency and handshake-stability checks.
module tb_change_dispenser;

    localparam int AMT_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    change_dispenser_if #(.AMT_W(AMT_W)) bus ();

    change_dispenser #(.AMT_W(AMT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    int coin_q[$];
    int done_q[$];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Greedy change from plain division; returns number of coins
    task automatic push_exp(input int amt, output int n);
        int r, q, d, k;
        r = amt;
        q = 0;
`ifdef CHANGE_QUARTER_EN
        q = r / 5;
        r = r % 5;
`endif
        d = r / 2;
        k = r % 2;
        for (int i = 0; i < q; i++) coin_q.push_back(3);
        for (int i = 0; i < d; i++) coin_q.push_back(2);
        for (int i = 0; i < k; i++) coin_q.push_back(1);
        n = q + d + k;
        done_q.push_back(n);
    endtask

    // Monitor: transfers, done pulses, handshake stability
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [1:0] prev_coin  = 2'b00;

    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", int'(bus.coin_valid), 1);
                check("hold_coin", int'(bus.coin), int'(prev_coin));
            end
            if (bus.coin_valid && bus.coin_ready) begin
                if (coin_q.size() == 0)
                    check("unexpected_coin", int'(bus.coin), 0);
                else
                    check("coin", int'(bus.coin), coin_q.pop_front());
            end
            if (bus.done) begin
                if (done_q.size() == 0)
                    check("unexpected_done", 1, 0);
                else
                    check("coin_count", int'(bus.coin_count),
                          done_q.pop_front());
            end
            prev_valid = bus.coin_valid;
            prev_ready = bus.coin_ready;
            prev_coin  = bus.coin;
        end
    end

    function automatic bit ready_for(input int mode, input int cyc);
        case (mode)
            1:       return cyc > 3;
            2:       return $urandom_range(0, 9) < 7;
            default: return 1'b1;
        endcase
    endfunction

    // Entered at posedge+1 of an IDLE cycle; leaves at posedge+1 of the
    // IDLE cycle after done. mode 3 holds a spurious start (amount 7)
    // for the whole transaction, including the DONE cycle.
    task automatic run_txn(input int amt, input int mode);
        int n, cyc, stalls;
        bit seen;
        push_exp(amt, n);
        bus.start  = 1'b1;
        bus.amount = AMT_W'(amt);
        @(posedge clock);
        #1;
        cyc    = 1;
        stalls = 0;
        seen   = 1'b0;
        bus.start = (mode == 3);
        if (mode == 3) bus.amount = AMT_W'(7);
        while (!seen && cyc <= 200) begin
            bus.coin_ready = ready_for(mode, cyc);
            @(negedge clock);
            if (cyc == 1) check("busy_c1", int'(bus.busy), 1);
            if (bus.done) begin
                seen = 1'b1;
                check("done_cycle", cyc, n + 1 + stalls);
                bus.start = 1'b0;
            end else if (bus.coin_valid && !bus.coin_ready) begin
                stalls++;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        if (!seen) check("done_timeout", 0, 1);
        check("idle_after_done", int'(bus.busy), 0);
        check("done_one_cycle", int'(bus.done), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_coin"}, int'(bus.coin), 0);
        check({tag, "_valid"}, int'(bus.coin_valid), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_count"}, int'(bus.coin_count), 0);
    endtask

    initial begin
        int amt, mode;
        bus.start      = 1'b0;
        bus.amount     = '0;
        bus.coin_ready = 1'b0;

        repeat (2) @(negedge clock);
        check_reset_vals("rst");
        @(posedge clock);
        #1;
        reset = 1'b0;

        run_txn(3, 0);
        check("count_hold", int'(bus.coin_count), 2);
        run_txn(0, 0);
        run_txn(4, 1);
        run_txn(5, 3);
        run_txn(7, 0);
        run_txn(15, 2);

        // Abandon an amount-6 transaction after the first dime
        begin
            int n;
            push_exp(6, n);
            bus.start  = 1'b1;
            bus.amount = AMT_W'(6);
            @(posedge clock);
            #1;
            bus.start      = 1'b0;
            bus.coin_ready = 1'b1;
            @(posedge clock);
            #1;
            reset = 1'b1;
            coin_q.delete();
            done_q.delete();
            @(negedge clock);
            check_reset_vals("midrst");
            @(posedge clock);
            #1;
            reset = 1'b0;
        end
        run_txn(1, 0);

        for (int i = 0; i < 40; i++) begin
            amt  = $urandom_range(0, 15);
            mode = $urandom_range(0, 3);
            run_txn(amt, mode);
        end

        check("coin_q_drained", coin_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
